// File: rtl/alu_arbiter.sv
// Round-robin arbiter that fronts one shared combinational ALU for two requesters.
// Define ALU_ARBITER_ASSERT_EN to compile in the protocol assertions.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [3:0] req0_x,
  input  logic [3:0] req0_y,
  input  logic [3:0] req1_x,
  input  logic [3:0] req1_y,
  input  logic [2:0] req0_sel,
  input  logic [2:0] req1_sel,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic [2:0] alu_select,
  input  logic [3:0] alu_data_out,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_cout
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last;   // 1: req1 was granted most recently
  logic       grant0;
  logic       grant1;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last)) grant0 = 1'b1;
      else if (req1_valid)                     grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last       <= 1'b1;
      alu_x      <= 4'd0;
      alu_y      <= 4'd0;
      alu_select <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= 4'd0;
      rsp_cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A grant implies its valid, so a grant is an acceptance.
          if (grant0 || grant1) begin
            alu_x      <= grant1 ? req1_x   : req0_x;
            alu_y      <= grant1 ? req1_y   : req0_y;
            alu_select <= grant1 ? req1_sel : req0_sel;
            rsp_id     <= grant1;
            last       <= grant1;
            cnt        <= CNT_LOAD;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_data  <= alu_data_out;
            rsp_cout  <= alu_cout;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_ASSERT_EN
  a_req0_known: assert property (@(posedge clk) disable iff (!rst_n)
    req0_valid |-> !$isunknown({req0_x, req0_y, req0_sel}));
  a_req1_known: assert property (@(posedge clk) disable iff (!rst_n)
    req1_valid |-> !$isunknown({req1_x, req1_y, req1_sel}));
  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));
  a_alu_stable: assert property (@(posedge clk) disable iff (!rst_n)
    state == EXEC |=> $stable({alu_x, alu_y, alu_select}));
  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid && !rsp_ready |=> rsp_valid && $stable({rsp_data, rsp_cout, rsp_id}));
  a_capture_known: assert property (@(posedge clk) disable iff (!rst_n)
    state == EXEC && cnt == 4'd0 |-> !$isunknown({alu_data_out, alu_cout}));
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table for arbitration and results,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_arbiter;

  localparam int EXEC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_x, req0_y, req1_x, req1_y;
  logic [2:0] req0_sel, req1_sel;
  logic [3:0] alu_x, alu_y, alu_data_out;
  logic [2:0] alu_select;
  logic       alu_cout;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [3:0] rsp_data;
  logic [4:0] alu_res;

  int passed = 0;
  int total  = 0;

  alu_arbiter #(.EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req1_x(req1_x), .req1_y(req1_y),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .alu_x(alu_x), .alu_y(alu_y), .alu_select(alu_select),
    .alu_data_out(alu_data_out), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  // Shared ALU: 0 add, 1 sub (cout = borrow), 2 and, 3 or, 4 xor, 5 add+1, 6 shl, 7 pass x
  always_comb begin
    alu_res = 5'd0;
    case (alu_select)
      3'd0: alu_res = {1'b0, alu_x} + {1'b0, alu_y};
      3'd1: alu_res = {1'b0, alu_x} - {1'b0, alu_y};
      3'd2: alu_res = {1'b0, alu_x & alu_y};
      3'd3: alu_res = {1'b0, alu_x | alu_y};
      3'd4: alu_res = {1'b0, alu_x ^ alu_y};
      3'd5: alu_res = {1'b0, alu_x} + {1'b0, alu_y} + 5'd1;
      3'd6: alu_res = {alu_x, 1'b0};
      default: alu_res = {1'b0, alu_x};
    endcase
  end
  assign alu_data_out = alu_res[3:0];
  assign alu_cout     = alu_res[4];

  typedef struct {
    logic       v0, v1;
    logic [3:0] x0, y0;
    logic [2:0] s0;
    logic [3:0] x1, y1;
    logic [2:0] s1;
    logic       id;
    logic [3:0] data;
    logic       cout;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Starts at the negedge after the acceptance edge; ends at a negedge back in IDLE.
  task automatic finish_op(input string tag, input logic [10:0] alu_exp, input logic id,
                           input logic [3:0] data, input logic cout, input int hold);
    logic [5:0] rsp_exp;
    rsp_exp = {id, cout, data};
    rsp_ready = (hold == 0);
    for (int k = 0; k < EXEC; k++) begin
      check({tag, "_alu"}, {alu_x, alu_y, alu_select}, alu_exp);
      check({tag, "_early_valid"}, rsp_valid, 1'b0);
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_valid"}, rsp_valid, 1'b1);
      check({tag, "_hold_rsp"}, {rsp_id, rsp_cout, rsp_data}, rsp_exp);
      check({tag, "_hold_req1_ready"}, req1_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_rsp"}, {rsp_id, rsp_cout, rsp_data}, rsp_exp);
    check({tag, "_alu_resp"}, {alu_x, alu_y, alu_select}, alu_exp);
    @(negedge clk);
    check({tag, "_valid_clear"}, rsp_valid, 1'b0);
  endtask

  // Called at a negedge.
  task automatic do_op(input vec_t v, input string tag);
    bit ok;
    logic [10:0] alu_exp;
    req0_valid = v.v0; req0_x = v.x0; req0_y = v.y0; req0_sel = v.s0;
    req1_valid = v.v1; req1_x = v.x1; req1_y = v.y1; req1_sel = v.s1;
    rsp_ready  = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      check({tag, "_ready_timeout"}, 16'd0, 16'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      return;
    end
    check({tag, "_grant"}, {req1_ready, req0_ready}, v.id ? 16'd2 : 16'd1);
    alu_exp = v.id ? {v.x1, v.y1, v.s1} : {v.x0, v.y0, v.s0};
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    finish_op(tag, alu_exp, v.id, v.data, v.cout, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vec_t v;
    //        v0    v1    x0       y0       s0    x1       y1       s1    id    data     cout
    vecs[0] = '{1'b1, 1'b0, 4'b1010, 4'b0001, 3'd5, 4'b0000, 4'b0000, 3'd0, 1'b0, 4'b1100, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'b0011, 4'b0100, 3'd0, 4'b1111, 4'b0001, 3'd0, 1'b1, 4'b0000, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 4'b1001, 4'b1000, 3'd0, 4'b0101, 4'b0101, 3'd2, 1'b0, 4'b0001, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 3'd3, 4'b0111, 4'b0001, 3'd1, 1'b1, 4'b0110, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 3'd0, 4'b0010, 4'b0101, 3'd1, 1'b1, 4'b1101, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 4'b1100, 4'b1010, 3'd2, 4'b0001, 4'b0001, 3'd0, 1'b0, 4'b1000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 4'b0110, 4'b0011, 3'd4, 4'b0000, 4'b0000, 3'd0, 1'b0, 4'b0101, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 3'd0, 4'b1011, 4'b0000, 3'd6, 1'b1, 4'b0110, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 3'd0, 4'b0101, 4'b1010, 3'd3, 1'b1, 4'b1111, 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = 4'd0; req0_y = 4'd0; req0_sel = 3'd0;
    req1_x = 4'd0; req1_y = 4'd0; req1_sel = 3'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_alu", {alu_x, alu_y, alu_select}, 16'd0);
    check("reset_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_data}, 16'd0);
    rst_n = 1'b1;

    // rsp_ready high in IDLE must not produce anything
    rsp_ready = 1'b1;
    @(negedge clk);
    check("idle_rsp_ready_ignored", rsp_valid, 1'b0);

    for (int i = 0; i < 9; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held 5 cycles while req1 waits, then req1 accepted right after IDLE.
    req0_valid = 1'b1; req0_x = 4'b0101; req0_y = 4'b0011; req0_sel = 3'd0;
    rsp_ready = 1'b0;
    wait_ready(ok);
    check("bp_grant", {req1_ready, req0_ready}, ok ? 16'd1 : 16'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_x = 4'b0001; req1_y = 4'b0001; req1_sel = 3'd0;
    #1;
    check("bp_req1_blocked_exec", req1_ready, 1'b0);
    finish_op("bp", {4'b0101, 4'b0011, 3'd0}, 1'b0, 4'b1000, 1'b0, 5);
    #1;
    check("bp_req1_ready_after_idle", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    finish_op("bp_req1", {4'b0001, 4'b0001, 3'd0}, 1'b1, 4'b0010, 1'b0, 0);

    // Reset mid-EXEC after a req0 grant: abort, clear outputs, and restore req0 tie priority.
    req0_valid = 1'b1; req0_x = 4'b1111; req0_y = 4'b1111; req0_sel = 3'd0;
    wait_ready(ok);
    check("rst_seq_grant", {req1_ready, req0_ready}, ok ? 16'd1 : 16'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_alu", {alu_x, alu_y, alu_select}, 16'd0);
    check("rst_async_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_data}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < EXEC + 2; k++) begin
      check("rst_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
    end
    v = '{1'b1, 1'b1, 4'b0010, 4'b0011, 3'd0, 4'b0100, 4'b0100, 3'd0, 1'b0, 4'b0101, 1'b0};
    do_op(v, "post_rst_tie");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
